// File: rtl/biquad8_zero_coeff_loader.sv
// Purpose: bus-writable staging of the biquad zero-section coefficients (B, A) and
//          bypass bit, serialized into the zero FIR as B, A, then an update strobe.
// Latency: 4 cycles from the commit write to coeff_update_o.
// Backpressure: none. Every write is acked one cycle later. A commit arriving
//          mid-sequence is held as a single pending flag.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_i/adr_i/dat_i  single-cycle register write (adr 0 B, 1 A, 2 control, 3 reserved)
//   ack_o           write acknowledge, one cycle after wr_i
//   busy_o          sequence running or commit pending
//   coeff_dat_o/coeff_wr_o  serialized coefficient and its load strobe
//   coeff_update_o  coefficient update strobe
//   bypass_o        bypass select, changes only together with coeff_update_o
module biquad8_zero_coeff_loader #(
    parameter int COEFF_BITS  = 18,
    parameter int WB_DAT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_i,
    input  logic [1:0]             adr_i,
    input  logic [WB_DAT_BITS-1:0] dat_i,
    output logic                   ack_o,
    output logic                   busy_o,
    output logic [COEFF_BITS-1:0]  coeff_dat_o,
    output logic                   coeff_wr_o,
    output logic                   coeff_update_o,
    output logic                   bypass_o
);

    typedef enum logic [1:0] {IDLE, LOAD_B, LOAD_A, UPDATE} state_t;

    state_t                state_q;
    logic                  pend_q;
    logic [COEFF_BITS-1:0] b_q, a_q, b_snap_q, a_snap_q;
    logic                  byp_q, byp_snap_q;

    logic [COEFF_BITS-1:0] b_d, a_d;
    logic                  byp_d;
    logic                  commit;

    // Upper data bits beyond the coefficient width are intentionally dropped.
    logic unused_dat_hi;
    assign unused_dat_hi = ^dat_i[WB_DAT_BITS-1:COEFF_BITS];

    // Next staging values include the write of this cycle, so a snapshot taken
    // on this edge sees a bypass bit delivered with the commit itself.
    always_comb begin
        b_d    = b_q;
        a_d    = a_q;
        byp_d  = byp_q;
        commit = wr_i && (adr_i == 2'd2) && dat_i[0];
        if (wr_i) begin
            case (adr_i)
                2'd0:    b_d   = dat_i[COEFF_BITS-1:0];
                2'd1:    a_d   = dat_i[COEFF_BITS-1:0];
                2'd2:    byp_d = dat_i[1];
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != IDLE) || pend_q;

    // Outputs are registered from the current state, so each strobe appears
    // one cycle after the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pend_q         <= 1'b0;
            b_q            <= '0;
            a_q            <= '0;
            byp_q          <= 1'b0;
            b_snap_q       <= '0;
            a_snap_q       <= '0;
            byp_snap_q     <= 1'b0;
            ack_o          <= 1'b0;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;
            bypass_o       <= 1'b0;
        end else begin
            ack_o          <= wr_i;
            b_q            <= b_d;
            a_q            <= a_d;
            byp_q          <= byp_d;
            coeff_wr_o     <= 1'b0;
            coeff_update_o <= 1'b0;

            // Commits while a sequence runs collapse into one pending request.
            if (commit && (state_q != IDLE)) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (commit || pend_q) begin
                        state_q    <= LOAD_B;
                        pend_q     <= 1'b0;
                        b_snap_q   <= b_d;
                        a_snap_q   <= a_d;
                        byp_snap_q <= byp_d;
                    end
                end
                LOAD_B: begin
                    coeff_wr_o  <= 1'b1;
                    coeff_dat_o <= b_snap_q;
                    state_q     <= LOAD_A;
                end
                LOAD_A: begin
                    coeff_wr_o  <= 1'b1;
                    coeff_dat_o <= a_snap_q;
                    state_q     <= UPDATE;
                end
                UPDATE: begin
                    coeff_update_o <= 1'b1;
                    bypass_o       <= byp_snap_q;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/biquad8_zero_coeff_loader.md
BIQUAD8_ZERO_COEFF_LOADER -- requirements
Module: biquad8_zero_coeff_loader

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL have these parameters (name, default, meaning):
- COEFF_BITS, 18, coefficient width in Q4.14.
- WB_DAT_BITS, 32, bus data width.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- wr_i  in  1  bus write strobe, single cycle.
- adr_i  in  2  register address.
- dat_i  in  WB_DAT_BITS  bus write data.
- ack_o  out  1  write acknowledge.
- busy_o  out  1  load sequence in progress or pending.
- coeff_dat_o  out  COEFF_BITS  serialized coefficient to the zero FIR.
- coeff_wr_o  out  1  coefficient load strobe to the zero FIR.
- coeff_update_o  out  1  coefficient update strobe to the zero FIR.
- bypass_o  out  1  bypass select to the zero FIR.

Function
REQ-004 Register map SHALL be:
- adr 0: B staging, z^-1 coefficient.
- adr 1: A staging, z^0/z^-2 coefficient.
- adr 2: control; bit0 = commit (self-clearing), bit1 = bypass request.
- adr 3: reserved; the write is acked and ignored.
REQ-005 Staging writes SHALL capture dat_i[COEFF_BITS-1:0] and ignore the upper bits; no saturation.
REQ-006 ack_o SHALL pulse high exactly one cycle after each wr_i cycle, for every address, regardless of FSM state.
REQ-007 The FSM SHALL have states IDLE, LOAD_B, LOAD_A and UPDATE.
REQ-008 IDLE -> LOAD_B SHALL occur in the cycle after a commit write, or after a pending commit is present while in IDLE.
REQ-009 In LOAD_B: coeff_wr_o=1 and coeff_dat_o = B snapshot; next state LOAD_A.
REQ-010 In LOAD_A: coeff_wr_o=1 and coeff_dat_o = A snapshot; next state UPDATE.
REQ-011 In UPDATE: coeff_wr_o=0 and coeff_update_o=1; next state IDLE.
REQ-012 The B, A and bypass values SHALL be snapshotted on entry to LOAD_B; staging writes during a sequence SHALL NOT alter the sequence in flight.
REQ-013 coeff_wr_o and coeff_update_o SHALL NEVER be high in the same cycle.
REQ-014 Outside LOAD_B and LOAD_A, coeff_wr_o SHALL be 0 and coeff_dat_o SHALL hold its last value.
REQ-015 bypass_o SHALL change only in the UPDATE cycle, taking the snapshotted bypass bit, so that bypass and new coefficients take effect together.
REQ-016 A commit write while not in IDLE SHALL set a single pending flag; multiple commits while busy collapse into one.
REQ-017 The pending flag SHALL clear on entry to LOAD_B, and the next sequence uses staging contents as of that entry.
REQ-018 busy_o SHALL be high when the state is not IDLE or the pending flag is set.
REQ-019 Latency from the commit write cycle to the coeff_update_o pulse SHALL be exactly 4 cycles (LOAD_B at +1, LOAD_A at +2, UPDATE at +3, IDLE at +4 with update registered).
REQ-020 A pending commit SHALL start LOAD_B in the first cycle after returning to IDLE, giving back-to-back sequences with one IDLE cycle between them.

Reset
REQ-021 On rst: state=IDLE; pending=0; B=A=0; coeff_dat_o=0; coeff_wr_o=0; coeff_update_o=0; bypass_o=0; ack_o=0; busy_o=0.
REQ-022 rst asserted mid-sequence SHALL abort the sequence with no coeff_update_o pulse, and outputs SHALL reach reset values the next cycle.
REQ-023 A wr_i coincident with rst SHALL be dropped and not acked.

Verification
REQ-024 Basic load: write adr0=0x00123, adr1=0x3FFFF, adr2=0x1 -> coeff_wr_o high 2 cycles with coeff_dat_o 0x00123 then 0x3FFFF; coeff_update_o high the following cycle; ack_o after each write.
REQ-025 Bypass: write adr2=0x3 -> bypass_o rises only in the coeff_update_o cycle; write adr2=0x1 -> bypass_o falls in that sequence's update cycle.
REQ-026 Busy commit: commit, then during LOAD_A write adr0=0x00055 and commit twice -> first sequence uses the old B; exactly one further sequence with B=0x00055; busy_o low after it.
REQ-027 Reset mid-sequence: assert rst in the LOAD_A cycle -> no coeff_update_o pulse; all outputs 0 next cycle; a subsequent commit runs normally.
REQ-028 Truncation and reserved address: write adr0=0xFFFC0001 -> coeff_dat_o=0x00001 in LOAD_B; write adr3 -> acked with no state change.
REQ-029 Invariant check over random bus traffic: coeff_wr_o and coeff_update_o never overlap; every update is preceded by exactly two wr cycles.
